// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a two-flop input synchronizer and 3-sample majority vote.
// Received bytes land in a first-word-fall-through FIFO that the host drains with rd_en.
module uart_rx_fifo #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int fifo_depth = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  input  logic                        rd_en,
  output logic [7:0]                  dout,
  output logic                        valid,
  output logic                        full,
  output logic [$clog2(fifo_depth):0] count,
  output logic                        donerx,
  output logic                        frame_err,
  output logic                        overrun
);

  // state | meaning
  // IDLE  | line idle, waiting for rxs=0
  // START | start bit; a majority of 1 is a glitch and aborts
  // DATA  | data bits 1..8, LSB first, shifted into shreg
  // STOP  | stop bit; push, overrun or framing error at its midpoint
  // BRK   | after a framing error, wait for the line to return high

  localparam int CLKCOUNT = clk_freq / baud_rate;
  localparam int HALF     = CLKCOUNT / 2;
  localparam int CW       = $clog2(CLKCOUNT);
  localparam int AW       = $clog2(fifo_depth);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKCOUNT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(fifo_depth);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic          rx_s1, rxs;
  logic [CW-1:0] cnt;
  logic [3:0]    bi;
  logic          samp0, samp1;
  logic [7:0]    shreg;
  logic [7:0]    mem [fifo_depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          maj, decide, push, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
    end
  end

  // Third vote is the live synchronizer output on the decision edge.
  assign maj    = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
  assign decide = (cnt == CNT_DEC);
  assign push   = (state == STOP) && decide && maj && (!full || rd_en);
  assign pop    = rd_en && valid;

  assign valid = (count != '0);
  assign full  = (count == DEPTH);
  assign dout  = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bi        <= '0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      shreg     <= '0;
      donerx    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      donerx    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (state == START || state == DATA || state == STOP) begin
        if (cnt == CNT_S0) samp0 <= rxs;
        if (cnt == CNT_S1) samp1 <= rxs;
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          bi  <= bi + 4'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            bi    <= '0;
          end
        end
        START: begin
          if (decide && maj) state <= IDLE;
          else if (cnt == CNT_LAST) state <= DATA;
        end
        DATA: begin
          if (decide) shreg <= {maj, shreg[7:1]};
          if (cnt == CNT_LAST && bi == 4'd8) state <= STOP;
        end
        STOP: begin
          // Returning to IDLE at the stop midpoint re-arms for the next start edge.
          if (decide) begin
            if (!maj) begin
              frame_err <= 1'b1;
              state     <= BRK;
            end else if (push) begin
              donerx <= 1'b1;
              state  <= IDLE;
            end else begin
              overrun <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        BRK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (104 clocks per bit).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       valid, full;
  logic [3:0] count;
  logic       donerx, frame_err, overrun;

  int total = 0;
  int bad = 0;
  int n_done = 0, n_fe = 0, n_ov = 0, n_multi = 0;

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .dout(dout), .valid(valid),
    .full(full), .count(count), .donerx(donerx), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (donerx) n_done++;
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
      if ((int'(donerx) + int'(frame_err) + int'(overrun)) > 1) n_multi++;
    end
  end

  // Bit i is placed on rx just after an edge and held for 104 edges; the
  // optional spike inverts rx for the one edge that feeds the cnt=HALF sample.
  task automatic send_frame(input logic [7:0] data, input logic stopv, input bit spike,
                            input int stop_cycles);
    logic [9:0] bits;
    int cyc;
    bits = {stopv, data, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      cyc = (i == 9) ? stop_cycles : 104;
      rx = bits[i];
      if (spike) begin
        repeat (53) @(posedge clk);
        #1 rx = ~bits[i];
        @(posedge clk);
        #1 rx = bits[i];
        repeat (cyc - 54) @(posedge clk);
        #1;
      end else begin
        repeat (cyc) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic clear_counts();
    n_done = 0; n_fe = 0; n_ov = 0;
  endtask

  task automatic test_reset();
    #23;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if ({valid, full, donerx, frame_err, overrun} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {valid, full, donerx, frame_err, overrun}); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_single();
    clear_counts();
    send_frame(8'hA5, 1'b1, 1'b0, 56);
    total++; if (donerx !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL single_early: donerx=%b valid=%b want 0 0 at E991", donerx, valid); end
    @(posedge clk); #1;
    total++; if (donerx !== 1'b1) begin bad++; $display("FAIL single_donerx_e992: got %b want 1", donerx); end
    total++; if (dout !== 8'hA5 || valid !== 1'b1 || count !== 4'd1) begin bad++; $display("FAIL single_data: dout=%h valid=%b count=%0d want a5 1 1", dout, valid, count); end
    @(posedge clk); #1;
    total++; if (donerx !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", donerx); end
    repeat (60) @(posedge clk); #1;
    pop_one();
    total++; if (valid !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL single_pop: valid=%b count=%0d want 0 0", valid, count); end
  endtask

  task automatic test_glitch();
    clear_counts();
    @(posedge clk); #1 rx = 1'b0;
    repeat (20) @(posedge clk);
    #1 rx = 1'b1;
    repeat (300) @(posedge clk); #1;
    total++; if (n_done !== 0 || n_fe !== 0 || count !== 4'd0) begin bad++; $display("FAIL glitch_reject: done=%0d fe=%0d count=%0d want 0 0 0", n_done, n_fe, count); end
    send_frame(8'h3C, 1'b1, 1'b1, 104);
    total++; if (dout !== 8'h3C || count !== 4'd1 || n_done !== 1) begin bad++; $display("FAIL majority_3c: dout=%h count=%0d done=%0d want 3c 1 1", dout, count, n_done); end
    pop_one();
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_frame(8'h55, 1'b0, 1'b0, 104);
    repeat (208) @(posedge clk); #1;
    total++; if (n_fe !== 1) begin bad++; $display("FAIL frame_err_pulses: got %0d want 1", n_fe); end
    total++; if (n_done !== 0 || count !== 4'd0) begin bad++; $display("FAIL frame_err_nopush: done=%0d count=%0d want 0 0", n_done, count); end
    rx = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h12, 1'b1, 1'b0, 104);
    total++; if (dout !== 8'h12 || count !== 4'd1 || n_done !== 1) begin bad++; $display("FAIL after_break_12: dout=%h count=%0d done=%0d want 12 1 1", dout, count, n_done); end
    pop_one();
  endtask

  task automatic test_overrun_collision();
    logic [7:0] exp;
    clear_counts();
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b1, 1'b0, 104);
      if (k == 8) begin
        total++; if (full !== 1'b1 || count !== 4'd8 || n_ov !== 0) begin bad++; $display("FAIL fill_8: full=%b count=%0d ov=%0d want 1 8 0", full, count, n_ov); end
      end
    end
    total++; if (n_ov !== 1 || count !== 4'd8 || n_done !== 8) begin bad++; $display("FAIL overrun_9th: ov=%0d count=%0d done=%0d want 1 8 8", n_ov, count, n_done); end
    total++; if (dout !== 8'h01) begin bad++; $display("FAIL overrun_head: got %h want 01", dout); end
    clear_counts();
    send_frame(8'h77, 1'b1, 1'b0, 56);
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    total++; if (donerx !== 1'b1 || overrun !== 1'b0) begin bad++; $display("FAIL collision_pulse: donerx=%b overrun=%b want 1 0", donerx, overrun); end
    total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL collision_count: count=%0d full=%b want 8 1", count, full); end
    repeat (60) @(posedge clk); #1;
    for (int k = 2; k <= 9; k++) begin
      exp = (k == 9) ? 8'h77 : 8'(k);
      total++; if (dout !== exp || valid !== 1'b1) begin bad++; $display("FAIL drain_%0d: dout=%h valid=%b want %h 1", k, dout, valid, exp); end
      pop_one();
    end
    total++; if (valid !== 1'b0 || count !== 4'd0 || n_ov !== 0) begin bad++; $display("FAIL drain_empty: valid=%b count=%0d ov=%0d want 0 0 0", valid, count, n_ov); end
    pop_one();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL pop_empty: count=%0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_frame(8'h81, 1'b1, 1'b0, 104);
    send_frame(8'h42, 1'b1, 1'b0, 104);
    total++; if (count !== 4'd2 || n_done !== 2) begin bad++; $display("FAIL b2b_count: count=%0d done=%0d want 2 2", count, n_done); end
    total++; if (dout !== 8'h81) begin bad++; $display("FAIL b2b_first: got %h want 81", dout); end
    pop_one();
    total++; if (dout !== 8'h42) begin bad++; $display("FAIL b2b_second: got %h want 42", dout); end
    pop_one();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    clear_counts();
    send_frame(8'h5A, 1'b1, 1'b0, 104);
    total++; if (count !== 4'd1) begin bad++; $display("FAIL pre_reset_count: got %0d want 1", count); end
    d = 8'hF0;
    @(posedge clk); #1 rx = 1'b0;
    repeat (104) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx = d[i];
      repeat (104) @(posedge clk);
    end
    #1 rx = d[4];
    repeat (50) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    total++; if (count !== 4'd0 || {valid, full, donerx, frame_err, overrun} !== 5'b0 || dout !== 8'h00) begin bad++; $display("FAIL reset_midframe: count=%0d flags=%b dout=%h want 0 00000 00", count, {valid, full, donerx, frame_err, overrun}, dout); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h0F, 1'b1, 1'b0, 104);
    total++; if (count !== 4'd1 || dout !== 8'h0F) begin bad++; $display("FAIL after_reset_0f: count=%0d dout=%h want 1 0f", count, dout); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun_collision();
    test_back_to_back();
    test_reset_midframe();
    total++; if (n_multi !== 0) begin bad++; $display("FAIL pulse_exclusive: got %0d overlaps want 0", n_multi); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
